// File: rtl/m_estados_if.sv
// Sensor-to-indicator bundle for the temperature-supervision FSM.
// master drives the threshold/emergency inputs; slave drives the indicators.
// Carries no clock; clk and reset stay plain ports on the block.
interface m_estados_if;
   logic t_25;
   logic t_27;
   logic t_30;
   logic t_corp;
   logic notif;
   logic aban;
   logic alarm;

   modport master (
      output t_25, t_27, t_30, t_corp,
      input  notif, aban, alarm
   );

   modport slave (
      input  t_25, t_27, t_30, t_corp,
      output notif, aban, alarm
   );
endinterface

// File: rtl/m_estados.sv
// Purpose: Moore FSM escalating NORMAL/NOTIFY/EVAC/ALARM from temperature thresholds, glitch-filtered up, hysteretic down.
// Latency: PERSIST edges to escalate, HOLD edges to de-escalate, 1 edge on t_corp; outputs are registered.
// Backpressure: none (free-running supervisor). Optional macro ALARM_LATCH_EN makes ALARM sticky until reset.
module m_estados #(
   parameter int unsigned PERSIST = 2,
   parameter int unsigned HOLD    = 4
) (
   input  logic        clk,
   input  logic        reset,
   m_estados_if.slave  bus
);

   typedef enum logic [1:0] {
      NORMAL = 2'd0,
      NOTIFY = 2'd1,
      EVAC   = 2'd2,
      ALARM  = 2'd3
   } state_t;

   // Terminal counts; counters clear on reaching them so they never wrap.
   localparam logic [7:0] PERSIST_TC = 8'(PERSIST - 1);
   localparam logic [7:0] HOLD_TC    = 8'(HOLD - 1);

   state_t     state_q, state_d;
   logic [7:0] up_cnt_q, up_cnt_d;
   logic [7:0] dn_cnt_q, dn_cnt_d;
   logic       notif_q, aban_q, alarm_q;
   logic [1:0] req_lvl;
   logic [1:0] cur_lvl;
   logic       may_drop;

   // Requested level from the thresholds by priority; inputs need not be one-hot.
   always_comb begin
      req_lvl = 2'd0;
      if (bus.t_corp || bus.t_30) begin
         req_lvl = 2'd3;
      end else if (bus.t_27) begin
         req_lvl = 2'd2;
      end else if (bus.t_25) begin
         req_lvl = 2'd1;
      end
   end

   // Next state and counters: override first, then filtered escalation or hysteretic drop.
   always_comb begin
      state_d  = state_q;
      up_cnt_d = 8'd0;
      dn_cnt_d = 8'd0;
      cur_lvl  = state_q;
`ifdef ALARM_LATCH_EN
      may_drop = (state_q != ALARM);
`else
      may_drop = 1'b1;
`endif
      case (state_q)
         NORMAL, NOTIFY, EVAC, ALARM: begin
            if (bus.t_corp) begin
               state_d = ALARM;
            end else if (req_lvl > cur_lvl) begin
               if (up_cnt_q == PERSIST_TC) begin
                  state_d = state_t'(req_lvl);
               end else begin
                  up_cnt_d = up_cnt_q + 8'd1;
               end
            end else if ((req_lvl < cur_lvl) && may_drop) begin
               if (dn_cnt_q == HOLD_TC) begin
                  state_d = state_t'(req_lvl);
               end else begin
                  dn_cnt_d = dn_cnt_q + 8'd1;
               end
            end
         end
         default: begin
            state_d = NORMAL;
         end
      endcase
   end

   // State, counters and indicator registers; indicators track the next state so they switch with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= NORMAL;
         up_cnt_q <= 8'd0;
         dn_cnt_q <= 8'd0;
         notif_q  <= 1'b0;
         aban_q   <= 1'b0;
         alarm_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         up_cnt_q <= up_cnt_d;
         dn_cnt_q <= dn_cnt_d;
         notif_q  <= (state_d != NORMAL);
         aban_q   <= (state_d == EVAC) || (state_d == ALARM);
         alarm_q  <= (state_d == ALARM);
      end
   end

   assign bus.notif = notif_q;
   assign bus.aban  = aban_q;
   assign bus.alarm = alarm_q;

endmodule

// File: tb/tb_m_estados.sv
// Directed bench for m_estados with default PERSIST=2, HOLD=4.
// Indicators are compared as {notif, aban, alarm} one time unit after each rising edge.
// Expectations for the ALARM de-escalation step follow ALARM_LATCH_EN.
module tb_m_estados;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   m_estados_if bus ();

   m_estados dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [2:0] got, input logic [2:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] outs();
      return {bus.notif, bus.aban, bus.alarm};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic c, input logic t30, input logic t27, input logic t25);
      bus.t_corp = c;
      bus.t_30   = t30;
      bus.t_27   = t27;
      bus.t_25   = t25;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #1;
      reset = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      set_in(0, 0, 0, 0);

      // Reset and idle
      #12;
      check_eq("reset_state", outs(), 3'b000);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check_eq("idle_normal", outs(), 3'b000);
      end

      // Stepwise escalation
      set_in(0, 0, 0, 1);
      tick(); check_eq("t25_edge1", outs(), 3'b000);
      tick(); check_eq("t25_notify", outs(), 3'b100);
      set_in(0, 0, 1, 0);
      tick(); check_eq("t27_edge1", outs(), 3'b100);
      tick(); check_eq("t27_evac", outs(), 3'b110);
      set_in(0, 1, 0, 0);
      tick(); check_eq("t30_edge1", outs(), 3'b110);
      tick(); check_eq("t30_alarm", outs(), 3'b111);

      // Asynchronous reset clears ALARM without a clock edge
      pulse_reset();
      set_in(0, 0, 0, 0);
      check_eq("reset_from_alarm", outs(), 3'b000);

      // One-cycle glitch is filtered
      tick();
      set_in(0, 0, 1, 0);
      tick(); check_eq("glitch_edge1", outs(), 3'b000);
      set_in(0, 0, 0, 0);
      tick(); check_eq("glitch_gone", outs(), 3'b000);
      tick(); check_eq("glitch_still", outs(), 3'b000);

      // Emergency override needs one edge
      set_in(1, 0, 0, 0);
      tick(); check_eq("corp_alarm", outs(), 3'b111);
      set_in(0, 0, 0, 0);

      // De-escalation out of ALARM
      for (int i = 0; i < 3; i++) begin
         tick(); check_eq("alarm_hold", outs(), 3'b111);
      end
      tick();
`ifdef ALARM_LATCH_EN
      check_eq("alarm_latched", outs(), 3'b111);
      tick(); check_eq("alarm_latched_more", outs(), 3'b111);
      pulse_reset();
      check_eq("latch_reset", outs(), 3'b000);
`else
      check_eq("alarm_drop", outs(), 3'b000);
`endif

      // EVAC hysteresis, full drop
      set_in(0, 0, 1, 0);
      tick(); tick(); check_eq("evac_entry", outs(), 3'b110);
      set_in(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick(); check_eq("evac_hold", outs(), 3'b110);
      end
      tick(); check_eq("evac_drop", outs(), 3'b000);

      // Interrupted drop restarts the HOLD count
      set_in(0, 0, 1, 0);
      tick(); tick(); check_eq("evac_reentry", outs(), 3'b110);
      set_in(0, 0, 0, 0);
      tick(); tick(); tick();
      check_eq("evac_3drop", outs(), 3'b110);
      set_in(0, 0, 1, 0);
      tick(); check_eq("evac_restored", outs(), 3'b110);
      set_in(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick(); check_eq("evac_rehold", outs(), 3'b110);
      end
      tick(); check_eq("evac_redrop", outs(), 3'b000);

      // Non-one-hot request skips levels NORMAL -> ALARM
      set_in(0, 1, 0, 1);
      tick(); check_eq("skip_edge1", outs(), 3'b000);
      tick(); check_eq("skip_alarm", outs(), 3'b111);

      // Partial drop ALARM -> NOTIFY
      set_in(0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         tick(); check_eq("partial_hold", outs(), 3'b111);
      end
      tick();
`ifdef ALARM_LATCH_EN
      check_eq("partial_latched", outs(), 3'b111);
`else
      check_eq("partial_notify", outs(), 3'b100);
`endif

      // Reset asserted mid-cycle while in ALARM
      set_in(1, 0, 0, 0);
      tick(); check_eq("pre_async_alarm", outs(), 3'b111);
      #3;
      reset = 1'b1;
      #1;
      check_eq("async_reset_mid", outs(), 3'b000);
      set_in(0, 0, 0, 0);
      tick(); check_eq("held_in_reset", outs(), 3'b000);
      reset = 1'b0;
      tick(); check_eq("after_release", outs(), 3'b000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
